duck_sprite_renderer: RTL and testbench

DUCK_SPRITE_RENDERER -- requirements
Module: duck_sprite_renderer

---
 rtl/duck_sprite_pkg.sv | 8 +
 rtl/duck_anim_counter.sv | 45 ++++
 rtl/duck_sprite_renderer.sv | 142 ++++++++++++++
 tb/tb_duck_sprite_renderer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/duck_sprite_pkg.sv
// Shared screen geometry and coordinate type for the duck sprite renderer.
package duck_sprite_pkg;
   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int DEF_IDX_W = 4;

   typedef logic [9:0] coord_t;
endpackage

// File: rtl/duck_anim_counter.sv
// Animation sequencer: counts frame_start pulses and steps the sprite frame
// once every FRAME_TICKS video frames while animation is running.
module duck_anim_counter #(
   parameter int FRAMES      = 4,
   parameter int FRAME_TICKS = 8
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      frame_start_i,
   input  logic                      anim_run_i,
   output logic [$clog2(FRAMES)-1:0] frame_idx_o
);
   localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam int FIDX_W = $clog2(FRAMES);

   logic [TICK_W-1:0] tick_q, tick_d;
   logic [FIDX_W-1:0] frame_q, frame_d;

   // Next tick/frame: only moves on a running frame_start, so the frame never changes mid-frame
   always_comb begin
      tick_d  = tick_q;
      frame_d = frame_q;
      if (frame_start_i && anim_run_i) begin
         if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
            tick_d  = '0;
            frame_d = (frame_q == FIDX_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   // Tick and frame state
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tick_q  <= '0;
         frame_q <= '0;
      end else begin
         tick_q  <= tick_d;
         frame_q <= frame_d;
      end
   end

   assign frame_idx_o = frame_q;
endmodule

// File: rtl/duck_sprite_renderer.sv
// Duck sprite renderer: box test and ROM addressing in stage 0, ROM wait in
// stage 1, opaque-texel decision in stage 2 (2-cycle pixel latency).
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN,
// which adds the flip_x input.
module duck_sprite_renderer
   import duck_sprite_pkg::*;
#(
   parameter int SPR_W       = 64,
   parameter int SPR_H       = 64,
   parameter int FRAMES      = 4,
   parameter int SCALE_SHIFT = 0,
   parameter int FRAME_TICKS = 8,
   parameter int IDX_W       = DEF_IDX_W,
   parameter int TRANSP_IDX  = 0
) (
   input  logic                                     vga_clk,
   input  logic                                     reset,
   input  logic [9:0]                               DrawX,
   input  logic [9:0]                               DrawY,
   input  logic                                     blank,
   input  logic                                     frame_start,
   input  logic [9:0]                               pos_x,
   input  logic [9:0]                               pos_y,
   input  logic                                     anim_run,
`ifdef SPRITE_MIRROR_EN
   input  logic                                     flip_x,
`endif
   output logic [$clog2(FRAMES*SPR_W*SPR_H)-1:0]    rom_address,
   input  logic [IDX_W-1:0]                         rom_q,
   output logic [IDX_W-1:0]                         sprite_idx,
   output logic                                     sprite_hit,
   output logic [$clog2(FRAMES)-1:0]                frame_idx
);
   localparam int ADDR_W   = $clog2(FRAMES*SPR_W*SPR_H);
   localparam int LX_W     = $clog2(SPR_W);
   localparam int LY_W     = $clog2(SPR_H);
   localparam int FRAME_SZ = SPR_W * SPR_H;
   localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_SHIFT);
   localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_SHIFT);

   coord_t px_q, py_q;
`ifdef SPRITE_MIRROR_EN
   logic   flip_q;
`endif

   // Sprite position is frozen for a whole video frame, updated only at frame_start
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         px_q <= '0;
         py_q <= '0;
`ifdef SPRITE_MIRROR_EN
         flip_q <= 1'b0;
`endif
      end else if (frame_start) begin
         px_q <= pos_x;
         py_q <= pos_y;
`ifdef SPRITE_MIRROR_EN
         flip_q <= flip_x;
`endif
      end
   end

   duck_anim_counter #(
      .FRAMES      (FRAMES),
      .FRAME_TICKS (FRAME_TICKS)
   ) u_anim (
      .clk_i         (vga_clk),
      .reset_i       (reset),
      .frame_start_i (frame_start),
      .anim_run_i    (anim_run),
      .frame_idx_o   (frame_idx)
   );

   // Stage 0: box test in 11 bits so boxes past the screen edge clip instead of wrapping
   logic [10:0]     x11, y11, px11, py11;
   logic            in_box_c;
   coord_t          dx, dy;
   logic [LX_W-1:0] lx, lx_eff;
   logic [LY_W-1:0] ly;

   always_comb begin
      x11      = {1'b0, DrawX};
      y11      = {1'b0, DrawY};
      px11     = {1'b0, px_q};
      py11     = {1'b0, py_q};
      in_box_c = (x11 >= px11) && (x11 < px11 + BOX_W) && (x11 < 11'(SCREEN_W)) &&
                 (y11 >= py11) && (y11 < py11 + BOX_H) && (y11 < 11'(SCREEN_H));
      dx       = DrawX - px_q;
      dy       = DrawY - py_q;
      lx       = LX_W'(dx >> SCALE_SHIFT);
      ly       = LY_W'(dy >> SCALE_SHIFT);
`ifdef SPRITE_MIRROR_EN
      lx_eff   = flip_q ? LX_W'(SPR_W - 1) - lx : lx;
`else
      lx_eff   = lx;
`endif
   end

   // ROM address goes out this cycle; the synchronous ROM answers one cycle later
   always_comb begin
      rom_address = '0;
      if (in_box_c)
         rom_address = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SZ) +
                       ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx_eff);
   end

   // Stage 0/1 register: carry in_box and blank alongside the ROM read
   logic in_box_q, blank_q;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         in_box_q <= 1'b0;
         blank_q  <= 1'b0;
      end else begin
         in_box_q <= in_box_c;
         blank_q  <= blank;
      end
   end

   // Stage 2: a pixel is drawn only if inside the box, visible and not transparent
   logic             hit_d, hit_q;
   logic [IDX_W-1:0] idx_d, idx_q;

   always_comb begin
      hit_d = in_box_q && blank_q && (rom_q != IDX_W'(TRANSP_IDX));
      idx_d = hit_d ? rom_q : '0;
   end

   // Output registers
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hit_q <= 1'b0;
         idx_q <= '0;
      end else begin
         hit_q <= hit_d;
         idx_q <= idx_d;
      end
   end

   assign sprite_hit = hit_q;
   assign sprite_idx = idx_q;
endmodule

// File: tb/tb_duck_sprite_renderer.sv
// Directed bench for duck_sprite_renderer: position, scale, transparency,
// clipping, animation, reset and (with SPRITE_MIRROR_EN) mirroring.
module tb_duck_sprite_renderer;
   logic        vga_clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
   logic        blank = 1'b0, frame_start = 1'b0, anim_run = 1'b0;
`ifdef SPRITE_MIRROR_EN
   logic        flip_x = 1'b0;
`endif
   logic [3:0]  rom_const = '0;
   logic [3:0]  rom_q = '0, rom_q_s = '0;
   logic [13:0] rom_address, rom_address_s;
   logic [3:0]  sprite_idx, sprite_idx_s;
   logic        sprite_hit, sprite_hit_s;
   logic [1:0]  frame_idx, frame_idx_s;

   int n_chk = 0;
   int n_err = 0;

   always #5 vga_clk = ~vga_clk;

   // Synchronous ROM models: every texel reads as rom_const
   always @(posedge vga_clk) begin
      rom_q   <= rom_const;
      rom_q_s <= rom_const;
   end

   duck_sprite_renderer dut (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .anim_run(anim_run),
`ifdef SPRITE_MIRROR_EN
      .flip_x(flip_x),
`endif
      .rom_address(rom_address), .rom_q(rom_q), .sprite_idx(sprite_idx),
      .sprite_hit(sprite_hit), .frame_idx(frame_idx)
   );

   duck_sprite_renderer #(.SCALE_SHIFT(1)) dut_s (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .anim_run(anim_run),
`ifdef SPRITE_MIRROR_EN
      .flip_x(flip_x),
`endif
      .rom_address(rom_address_s), .rom_q(rom_q_s), .sprite_idx(sprite_idx_s),
      .sprite_hit(sprite_hit_s), .frame_idx(frame_idx_s)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge vga_clk);
      @(negedge vga_clk);
   endtask

   task automatic pix(input int x, input int y, input logic b);
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = b;
      #1;
   endtask

   task automatic set_pos(input int x, input int y);
      pos_x = 10'(x);
      pos_y = 10'(y);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         tick();
      end
   endtask

   initial begin
      @(negedge vga_clk);
      // Reset state
      pix(0, 0, 1'b1);
      rom_const = 4'd5;
      tick();
      chk("rst_hit", sprite_hit, 0);
      chk("rst_idx", sprite_idx, 0);
      chk("rst_frame", frame_idx, 0);
      tick();
      reset = 1'b0;

      // Position test, latency exactly 2
      set_pos(100, 50);
      pix(0, 0, 1'b1);
      tick(); tick();
      pix(100, 50, 1'b1);
      chk("pos_addr", rom_address, 0);
      tick();
      chk("pos_lat1_hit", sprite_hit, 0);
      tick();
      chk("pos_hit", sprite_hit, 1);
      chk("pos_idx", sprite_idx, 5);
      pix(163, 113, 1'b1);
      chk("pos_corner_addr", rom_address, 4095);
      tick(); tick();
      chk("pos_corner_hit", sprite_hit, 1);
      pix(164, 50, 1'b1);
      chk("pos_right_addr", rom_address, 0);
      tick(); tick();
      chk("pos_right_hit", sprite_hit, 0);
      pix(100, 114, 1'b1);
      tick(); tick();
      chk("pos_below_hit", sprite_hit, 0);

      // Transparency and blanking
      rom_const = 4'd0;
      pix(100, 50, 1'b1);
      tick(); tick();
      chk("transp_hit", sprite_hit, 0);
      chk("transp_idx", sprite_idx, 0);
      rom_const = 4'd7;
      pix(100, 50, 1'b0);
      tick(); tick();
      chk("blank_hit", sprite_hit, 0);
      chk("blank_idx", sprite_idx, 0);
      rom_const = 4'd5;

      // Scale test
      set_pos(0, 0);
      pix(3, 5, 1'b1);
      chk("scale_addr", rom_address_s, 129);
      chk("noscale_addr", rom_address, 323);
      pix(127, 0, 1'b1);
      tick(); tick();
      chk("scale_edge_hit", sprite_hit_s, 1);
      pix(128, 0, 1'b1);
      tick(); tick();
      chk("scale_past_hit", sprite_hit_s, 0);

      // Clipping: box at x=600 must not wrap to the left edge
      set_pos(600, 10);
      pix(0, 10, 1'b1);
      tick(); tick();
      chk("clip_x0_hit", sprite_hit, 0);
      pix(35, 10, 1'b1);
      tick(); tick();
      chk("clip_x35_hit", sprite_hit, 0);
      pix(620, 10, 1'b1);
      chk("clip_in_addr", rom_address, 20);
      tick(); tick();
      chk("clip_in_hit", sprite_hit, 1);

      // Animation
      set_pos(0, 0);
      anim_run = 1'b1;
      pulses(7);
      chk("anim_7", frame_idx, 0);
      pulses(1);
      chk("anim_8", frame_idx, 1);
      chk("anim_8_s", frame_idx_s, 1);
      pix(0, 0, 1'b1);
      chk("anim_f1_addr", rom_address, 4096);
      pulses(8);
      chk("anim_16", frame_idx, 2);
      pulses(8);
      chk("anim_24", frame_idx, 3);
      pulses(8);
      chk("anim_32", frame_idx, 0);
      pulses(8);
      chk("anim_40", frame_idx, 1);
      anim_run = 1'b0;
      pulses(8);
      chk("anim_hold", frame_idx, 1);

      // Reset mid-line
      set_pos(300, 200);
      pix(310, 210, 1'b1);
      tick(); tick();
      chk("pre_rst_hit", sprite_hit, 1);
      reset = 1'b1;
      tick();
      chk("midrst_hit", sprite_hit, 0);
      chk("midrst_idx", sprite_idx, 0);
      chk("midrst_frame", frame_idx, 0);
      reset = 1'b0;
      pix(2, 1, 1'b1);
      chk("postrst_addr", rom_address, 66);
      tick(); tick();
      chk("postrst_hit", sprite_hit, 1);

      // frame_start coinciding with a pixel uses the old position
      pos_x = 10'd100;
      pos_y = 10'd50;
      frame_start = 1'b1;
      pix(10, 0, 1'b1);
      chk("fs_old_addr", rom_address, 10);
      tick();
      frame_start = 1'b0;
      tick();
      chk("fs_old_hit", sprite_hit, 1);
      pix(10, 0, 1'b1);
      tick(); tick();
      chk("fs_new_hit", sprite_hit, 0);

`ifdef SPRITE_MIRROR_EN
      flip_x = 1'b1;
      set_pos(0, 0);
      flip_x = 1'b0;
      pix(0, 0, 1'b1);
      chk("mirror_addr", rom_address, 63);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
